// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, parity modes and helpers.
// Used by both the transmitter and receiver sides of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT,
        DONE
    } rx_state_t;

    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_EVEN = 2'b11;

    typedef struct packed {
        logic [3:0] len;
        logic [1:0] par;
        logic       stop2;
    } rx_cfg_t;

    // Lengths outside 5..8 fall back to 8 data bits.
    function automatic logic [3:0] uart_eff_len(input logic [3:0] len);
        return (len >= 4'd5 && len <= 4'd8) ? len : 4'd8;
    endfunction

    function automatic logic uart_parity(
        input logic [7:0] data,
        input logic [3:0] len,
        input logic [1:0] mode
    );
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < len) x = x ^ data[i];
        end
        case (mode)
            PAR_EVEN: return x;
            PAR_ODD:  return ~x;
            default:  return x;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous Rx pin.
// Flops reset to the idle (high) line level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic rx,
    output logic rx_sync
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d[0] = rx;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) sync_q <= '1;
        else        sync_q <= sync_d;
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: assembles one DATA_WIDTH-bit word from consecutive
// frames and hands it over with a single-cycle RX_done pulse.
module uart_receiver #(
    parameter int DATA_WIDTH  = 32,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  rx_tick,
    input  logic                  Rx,
    input  logic [3:0]            frame_length,
    input  logic [1:0]            parity_signal,
    input  logic                  stop_bits,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  RX_done,
    output logic                  RX_busy,
    output logic                  parity_error,
    output logic                  frame_error
);

    import uart_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [5:0] IDX_FULL = 6'(DATA_WIDTH);
    localparam logic [5:0] IDX_SAT  = 6'(DATA_WIDTH + 7);

    logic rx_sync;

    rx_state_t             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic [2:0]            frame_bit_q, frame_bit_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            frame_data_q, frame_data_d;
    logic                  par_acc_q, par_acc_d;
    logic                  frm_acc_q, frm_acc_d;
    logic                  from_wait_q, from_wait_d;
    rx_cfg_t               cfg_q, cfg_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  par_err_q, par_err_d;
    logic                  frm_err_q, frm_err_d;

    logic          tick_mid;
    logic          tick_end;
    logic [TW-1:0] tick_nxt;
    logic          stop_done;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .rx      (Rx),
        .rx_sync (rx_sync)
    );

    assign tick_mid = (tick_q == TICK_MID);
    assign tick_end = (tick_q == TICK_LAST);
    assign tick_nxt = tick_end ? '0 : tick_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_idx_d    = bit_idx_q;
        frame_bit_d  = frame_bit_q;
        word_d       = word_q;
        frame_data_d = frame_data_q;
        par_acc_d    = par_acc_q;
        frm_acc_d    = frm_acc_q;
        from_wait_d  = from_wait_q;
        cfg_d        = cfg_q;
        read_data_d  = read_data_q;
        par_err_d    = par_err_q;
        frm_err_d    = frm_err_q;
        stop_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_tick && !rx_sync) begin
                    state_d     = START;
                    tick_d      = TW'(1);
                    cfg_d.len   = uart_eff_len(frame_length);
                    cfg_d.par   = parity_signal;
                    cfg_d.stop2 = stop_bits;
                    word_d      = '0;
                    bit_idx_d   = '0;
                    frame_bit_d = '0;
                    par_acc_d   = 1'b0;
                    frm_acc_d   = 1'b0;
                    from_wait_d = 1'b0;
                end
            end
            WAIT: begin
                if (rx_tick && !rx_sync) begin
                    state_d     = START;
                    tick_d      = TW'(1);
                    from_wait_d = 1'b1;
                end
            end
            START: begin
                if (rx_tick) begin
                    tick_d = tick_nxt;
                    if (tick_mid && rx_sync) begin
                        state_d = from_wait_q ? WAIT : IDLE;
                        tick_d  = '0;
                    end else if (tick_end) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_tick) begin
                    tick_d = tick_nxt;
                    if (tick_mid) begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_idx_q == 6'(i)) word_d[i] = rx_sync;
                        end
                        frame_data_d[frame_bit_q] = rx_sync;
                        frame_bit_d = frame_bit_q + 3'd1;
                        if (bit_idx_q != IDX_SAT) begin
                            bit_idx_d = bit_idx_q + 6'd1;
                        end
                    end
                    // frame_bit wraps to 0 after eight bits, matching len 8
                    if (tick_end && frame_bit_q == cfg_q.len[2:0]) begin
                        state_d     = cfg_q.par[1] ? PARITY : STOP1;
                        frame_bit_d = '0;
                    end
                end
            end
            PARITY: begin
                if (rx_tick) begin
                    tick_d = tick_nxt;
                    if (tick_mid && rx_sync !=
                        uart_parity(frame_data_q, cfg_q.len, cfg_q.par)) begin
                        par_acc_d = 1'b1;
                    end
                    if (tick_end) state_d = STOP1;
                end
            end
            STOP1: begin
                if (rx_tick) begin
                    tick_d = tick_nxt;
                    if (tick_mid) begin
                        if (!rx_sync) frm_acc_d = 1'b1;
                        if (cfg_q.stop2) state_d = STOP2;
                        else             stop_done = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (rx_tick) begin
                    tick_d = tick_nxt;
                    if (tick_mid) begin
                        if (!rx_sync) frm_acc_d = 1'b1;
                        stop_done = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                tick_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs load on entry to DONE so they are valid with RX_done.
        if (stop_done) begin
            tick_d = '0;
            if (bit_idx_q >= IDX_FULL) begin
                state_d     = DONE;
                read_data_d = word_q;
                par_err_d   = par_acc_d;
                frm_err_d   = frm_acc_d;
            end else begin
                state_d = WAIT;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            frame_bit_q  <= '0;
            word_q       <= '0;
            frame_data_q <= '0;
            par_acc_q    <= 1'b0;
            frm_acc_q    <= 1'b0;
            from_wait_q  <= 1'b0;
            cfg_q        <= '0;
            read_data_q  <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_idx_q    <= bit_idx_d;
            frame_bit_q  <= frame_bit_d;
            word_q       <= word_d;
            frame_data_q <= frame_data_d;
            par_acc_q    <= par_acc_d;
            frm_acc_q    <= frm_acc_d;
            from_wait_q  <= from_wait_d;
            cfg_q        <= cfg_d;
            read_data_q  <= read_data_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
        end
    end

    assign read_data    = read_data_q;
    assign RX_done      = (state_q == DONE);
    assign RX_busy      = (state_q != IDLE) && (state_q != DONE);
    assign parity_error = par_err_q;
    assign frame_error  = frm_err_q;

endmodule
